// File: rtl/clock_monitor.sv
// clock_monitor: measures period/high time of a gated clock against a free-running
// reference clock and flags out-of-range periods and unexpected stalls.
module clock_monitor #(
    parameter int WIDTH      = 16,
    parameter int MIN_PERIOD = 4,
    parameter int MAX_PERIOD = 1000,
    parameter int TIMEOUT    = 2000
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_target,
    input  logic             i_expect,
    input  logic             i_clear,
    output logic             o_running,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high_time,
    output logic             o_period_valid,
    output logic             o_fault,
    output logic [1:0]       o_fault_code
);
    typedef enum logic [1:0] {STOPPED, ARMED, RUNNING} state_t;

    localparam logic [WIDTH-1:0] SAT    = '1;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] TMO    = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] TMO_M1 = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] MINP   = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] MAXP   = WIDTH'(MAX_PERIOD);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] per_cnt_q, per_cnt_d, high_cnt_q, high_cnt_d, idle_q, idle_d;
    logic [WIDTH-1:0] period_q, period_d, high_q, high_d;
    logic             valid_q, valid_d;
    logic [1:0]       fault_q, fault_d;
    logic             rise, fall, capture, stop;

    always_comb begin
        rise       = s2_q & ~s3_q;
        fall       = ~s2_q & s3_q;
        per_cnt_d  = rise ? ONE : (per_cnt_q == SAT) ? per_cnt_q : per_cnt_q + ONE;
        high_cnt_d = rise ? ONE : (s2_q && high_cnt_q != SAT) ? high_cnt_q + ONE : high_cnt_q;
        idle_d     = (rise | fall) ? '0 : (idle_q == TMO) ? idle_q : idle_q + ONE;
        // Stop on the edge where the idle count reaches TIMEOUT; a rise or fall always wins.
        stop       = !rise && !fall && idle_q == TMO_M1 && state_q != STOPPED;
        capture    = rise && state_q != STOPPED;
        state_d    = rise ? ((state_q == STOPPED) ? ARMED : RUNNING) : stop ? STOPPED : state_q;
        period_d   = capture ? per_cnt_q : period_q;
        high_d     = fall ? high_cnt_q : high_q;
        valid_d    = capture;
        fault_d    = {stop & i_expect, capture & (per_cnt_q < MINP || per_cnt_q > MAXP)}
                   | (fault_q & {2{~i_clear}});
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= STOPPED;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
            idle_q     <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            s1_q       <= i_target;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            per_cnt_q  <= per_cnt_d;
            high_cnt_q <= high_cnt_d;
            idle_q     <= idle_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

    assign o_running      = state_q == RUNNING;
    assign o_period       = period_q;
    assign o_high_time    = high_q;
    assign o_period_valid = valid_q;
    assign o_fault_code   = fault_q;
    assign o_fault        = |fault_q;
endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: scoreboard bench for clock_monitor; expected periods are queued
// when target rises are driven and checked when o_period_valid pulses.
module tb_clock_monitor;
    localparam int W = 16;

    logic         clk = 1'b0, rst_n = 1'b1, target = 1'b0, exp_r = 1'b0, clear = 1'b0;
    logic         o_running, o_period_valid, o_fault;
    logic [W-1:0] o_period, o_high_time;
    logic [1:0]   o_fault_code;
    int           vectors = 0, errors = 0, valid_seen = 0, mon_e = 0;
    int           exp_q[$];

    clock_monitor dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_target(target), .i_expect(exp_r), .i_clear(clear),
        .o_running(o_running), .o_period(o_period), .o_high_time(o_high_time),
        .o_period_valid(o_period_valid), .o_fault(o_fault), .o_fault_code(o_fault_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_period_valid) begin
            valid_seen++;
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: o_period=%0d with no capture expected", o_period);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_period !== W'(mon_e) || o_running !== 1'b1) begin
                    errors++;
                    $display("FAIL period_capture: got period=%0d running=%b, expected period=%0d running=1",
                             o_period, o_running, mon_e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wave(input int hi, input int lo, input int n, input bit armed);
        for (int i = 0; i < n; i++) begin
            if (i > 0 || armed) exp_q.push_back(hi + lo);
            target = 1'b1;
            step(hi);
            target = 1'b0;
            step(lo);
        end
    endtask

    task automatic drain(input string name);
        step(5);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d captures outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_running, o_period_valid, o_fault, o_fault_code, o_period, o_high_time} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got run=%b val=%b flt=%b code=%b per=%0d hi=%0d, expected all 0",
                     o_running, o_period_valid, o_fault, o_fault_code, o_period, o_high_time);
        end
        step(3);
        rst_n = 1'b1;
        step(3000);
        vectors++;
        if (valid_seen !== 0 || o_running !== 1'b0 || o_fault_code !== 2'b00 || o_period !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got valids=%0d run=%b code=%b per=%0d, expected 0 0 00 0",
                     valid_seen, o_running, o_fault_code, o_period);
        end
    endtask

    task automatic test_period();
        exp_r = 1'b1;
        wave(5, 5, 6, 1'b0);
        vectors++;
        if (o_running !== 1'b1 || o_high_time !== W'(5) || o_fault_code !== 2'b00 || valid_seen !== 5) begin
            errors++;
            $display("FAIL period10: got run=%b hi=%0d code=%b valids=%0d, expected 1 5 00 5",
                     o_running, o_high_time, o_fault_code, valid_seen);
        end
    endtask

    task automatic test_stall_fault();
        step(1997);
        vectors++;
        if (o_running !== 1'b1) begin
            errors++;
            $display("FAIL stall_early: got run=%b, expected 1", o_running);
        end
        step(1);
        vectors++;
        if (o_running !== 1'b0 || o_fault_code !== 2'b10 || o_fault !== 1'b1) begin
            errors++;
            $display("FAIL stall_fault: got run=%b code=%b flt=%b, expected 0 10 1",
                     o_running, o_fault_code, o_fault);
        end
        drain("stall");
    endtask

    task automatic test_legal_stop();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        vectors++;
        if (o_fault_code !== 2'b00) begin
            errors++;
            $display("FAIL clear_stall: got code=%b, expected 00", o_fault_code);
        end
        wave(5, 5, 4, 1'b0);
        exp_r = 1'b0;
        step(1997);
        vectors++;
        if (o_running !== 1'b1) begin
            errors++;
            $display("FAIL legal_stop_early: got run=%b, expected 1", o_running);
        end
        step(1);
        vectors++;
        if (o_running !== 1'b0 || o_fault_code !== 2'b00) begin
            errors++;
            $display("FAIL legal_stop: got run=%b code=%b, expected 0 00", o_running, o_fault_code);
        end
        drain("legal_stop");
    endtask

    task automatic test_range_fault();
        int n = 0;
        wave(600, 600, 2, 1'b0);
        vectors++;
        if (o_fault_code !== 2'b01 || o_running !== 1'b1 || o_period !== W'(1200)) begin
            errors++;
            $display("FAIL range_fault: got code=%b run=%b per=%0d, expected 01 1 1200",
                     o_fault_code, o_running, o_period);
        end
        step(10);
        vectors++;
        if (o_fault_code !== 2'b01) begin
            errors++;
            $display("FAIL range_sticky: got code=%b, expected 01", o_fault_code);
        end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        vectors++;
        if (o_fault_code !== 2'b00 || o_fault !== 1'b0) begin
            errors++;
            $display("FAIL range_clear: got code=%b flt=%b, expected 00 0", o_fault_code, o_fault);
        end
        exp_r = 1'b1;
        while (o_running === 1'b1 && n < 3000) begin
            step(1);
            n++;
        end
        vectors++;
        if (o_running !== 1'b0 || o_fault_code !== 2'b10) begin
            errors++;
            $display("FAIL range_then_stall: got run=%b code=%b after %0d cycles, expected 0 10",
                     o_running, o_fault_code, n);
        end
        drain("range");
    endtask

    task automatic test_clear_collision();
        int n = 0;
        target = 1'b1;
        step(600);
        target = 1'b0;
        step(600);
        exp_q.push_back(1200);
        target = 1'b1;
        step(2);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        vectors++;
        if (o_fault_code !== 2'b01 || o_fault !== 1'b1) begin
            errors++;
            $display("FAIL clear_collision: got code=%b flt=%b, expected 01 1", o_fault_code, o_fault);
        end
        step(597);
        target = 1'b0;
        exp_r = 1'b0;
        while (o_running === 1'b1 && n < 3000) begin
            step(1);
            n++;
        end
        vectors++;
        if (o_running !== 1'b0 || o_fault_code !== 2'b01) begin
            errors++;
            $display("FAIL collision_stop: got run=%b code=%b, expected 0 01", o_running, o_fault_code);
        end
        drain("collision");
    endtask

    task automatic test_reset_mid();
        exp_r = 1'b1;
        wave(5, 5, 4, 1'b0);
        drain("pre_reset");
        target = 1'b1;
        step(2);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_running, o_period_valid, o_fault, o_fault_code, o_period, o_high_time} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got run=%b val=%b flt=%b code=%b per=%0d hi=%0d, expected all 0",
                     o_running, o_period_valid, o_fault, o_fault_code, o_period, o_high_time);
        end
        step(2);
        rst_n = 1'b1;
        step(5);
        target = 1'b0;
        step(5);
        wave(5, 5, 3, 1'b1);
        vectors++;
        if (o_running !== 1'b1 || o_period !== W'(10) || o_fault_code !== 2'b00) begin
            errors++;
            $display("FAIL reset_restart: got run=%b per=%0d code=%b, expected 1 10 00",
                     o_running, o_period, o_fault_code);
        end
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_period();
        test_stall_fault();
        test_legal_stop();
        test_range_fault();
        test_clear_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/clock_monitor.md
Name: clock_monitor

Overview:
- Observes a generated, enable-gated clock (the consumer end of the clock generator) using a free-running reference clock.
- Reports whether the observed clock is running, its period and high time in reference cycles, and sticky faults for out-of-range period or unexpected stall.
- Used by testbenches and bring-up logic to confirm that clock gating starts and stops cleanly.

Parameters:
- WIDTH, 16, width of period/high-time counters and outputs.
- MIN_PERIOD, 4, smallest legal observed period in reference cycles; must be >= 4.
- MAX_PERIOD, 1000, largest legal observed period in reference cycles.
- TIMEOUT, 2000, reference cycles with no edge before the clock is declared stopped; must satisfy MAX_PERIOD < TIMEOUT <= 2^WIDTH-1.

Ports:
- i_clock  input  1  reference clock, rising-edge active.
- i_reset_n  input  1  asynchronous active-low reset.
- i_target  input  1  observed clock, asynchronous to i_clock.
- i_expect  input  1  high while the observed clock is intended to run; gates stall fault.
- i_clear  input  1  clears sticky fault bits.
- o_running  output  1  observed clock judged running.
- o_period  output  WIDTH  last measured period (rise to rise).
- o_high_time  output  WIDTH  last measured high time (rise to fall).
- o_period_valid  output  1  one-cycle pulse when o_period updates.
- o_fault  output  1  OR of o_fault_code.
- o_fault_code  output  2  bit0 period out of range, bit1 stall while expected; sticky.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state STOPPED, synchronizer flops 0, counters 0.
- i_target passes through a 2-flop synchronizer (s1, s2), then a delay flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - A high level first captured into s1 at edge k produces outputs updated at edge k+2.
- Period counter:
  - Loads 1 on rise; otherwise increments, saturating at 2^WIDTH-1.
  - On rise, the pre-load value is the number of reference cycles since the previous rise. A period of exactly 10 reference cycles yields 10.
- High counter:
  - Loads 1 on rise; increments while s2 is high; saturates.
  - On fall, o_high_time <= counter value.
- Idle counter: cleared on any rise or fall; otherwise increments, saturating at TIMEOUT.
- States:
  - STOPPED: on rise -> ARMED. No capture, because the period is unknown.
  - ARMED: on rise -> RUNNING; capture o_period and pulse o_period_valid. If the idle counter reaches TIMEOUT -> STOPPED.
  - RUNNING: on each rise, capture and pulse. If the idle counter reaches TIMEOUT -> STOPPED.
- o_running:
  - Set at the edge entering RUNNING.
  - Cleared at the edge entering STOPPED, exactly TIMEOUT cycles after the last detected edge.
- Range fault: any capture with value < MIN_PERIOD or > MAX_PERIOD sets bit0. The capture still occurs, and the state is unaffected.
- Stall fault: the ARMED/RUNNING -> STOPPED transition sets bit1 if i_expect is 1 in that cycle. With i_expect=0, stopping is legal gating and sets no fault.
- i_clear clears both bits next edge. If i_clear coincides with a new fault event, the new bit is set (set wins); other bits clear.
- Saturated period (no rise for 2^WIDTH-1 cycles) cannot be captured: TIMEOUT forces STOPPED first.
- Target already high at reset release: a rise is detected 2 cycles after release. This moves STOPPED -> ARMED only; no capture.
- Simultaneous rise and timeout cannot occur, because the rise clears the idle counter. Rise takes priority.
- Reset mid-operation: outputs drop to 0 immediately. Measurement restarts and needs two rises before o_period_valid.

Test Plan:
- Reset, i_target held 0 for 3000 cycles -> o_running=0, o_period_valid never pulses, o_fault_code=00.
- i_target period 10 (5 high/5 low), i_expect=1 -> first pulse at 2nd rise: o_period=10, o_running=1. From the first fall after the 2nd rise onward: o_high_time=5. Pulses repeat every 10 cycles; no fault.
- i_target period 1200 -> at 2nd rise: o_period=1200, o_fault_code=01, o_running=1. Fault holds until i_clear, then reads 00.
- Running at period 10, then i_target held low with i_expect=1 -> o_running falls 2000 cycles after the last fall, o_fault_code=10. Repeat with i_expect=0 -> o_running falls, o_fault_code=00.
- Period 1200 capture in the same cycle as i_clear=1 -> o_fault_code=01 afterwards.
- Assert i_reset_n=0 mid-RUNNING -> all outputs 0 within the same cycle. After release at period 10, the first o_period_valid arrives only at the 2nd detected rise.
